// File: rtl/acc_pkg.sv
// Shared widths and saturation helpers for the product accumulator.
// Define ACC_RELU_EN to clamp negative group results to zero.
package acc_pkg;

    localparam int MUL_LAT_DEF = 5;
    localparam int ACC_W_DEF   = 32;
    localparam int CNT_W       = 16;
    localparam int Y_W         = 16;

    function automatic longint acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam longint ACC_MAX = acc_max(ACC_W_DEF);
    localparam longint ACC_MIN = acc_min(ACC_W_DEF);

endpackage

// File: rtl/vld_delay.sv
// Fixed-depth shift register that keeps issue qualifiers
// aligned with the multiplier's product latency.
module vld_delay #(
    parameter int DEPTH = 5,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/acc_unit.sv
// Saturating group accumulator behind a fixed-latency multiplier.
// Define ACC_RELU_EN to clamp negative group results to zero.
import acc_pkg::*;

module acc_unit #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    issue_valid,
    input  logic                    issue_last,
    input  logic signed [Y_W-1:0]   y,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

    logic [1:0]       p_q;
    logic             p_valid;
    logic             p_last;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] res_d;
    logic [ACC_W:0]   sum_w;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             first_q;
    logic             hit_ovf;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_ovf_q;

    vld_delay #(
        .DEPTH(MUL_LAT),
        .W    (2)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .flush_i(clr),
        .d_i    ({issue_valid, issue_valid & issue_last}),
        .q_o    (p_q)
    );

    assign p_valid = p_q[1];
    assign p_last  = p_q[0];

    // One guard bit: overflow iff the top two bits disagree.
    always_comb begin
        sum_w = (first_q ? '0 : {acc_q[ACC_W-1], acc_q})
              + {{(ACC_W + 1 - Y_W){y[Y_W-1]}}, y};
        hit_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];
        if (!hit_ovf) begin
            acc_d = sum_w[ACC_W-1:0];
        end else if (sum_w[ACC_W]) begin
            acc_d = SAT_MIN;
        end else begin
            acc_d = SAT_MAX;
        end
        ovf_d = (first_q ? 1'b0 : ovf_q) | hit_ovf;
        if (first_q) begin
            cnt_d = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef ACC_RELU_EN
    assign res_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
    assign res_d = acc_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= p_valid & p_last;
            if (p_valid) begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
                first_q <= p_last;
                if (p_last) begin
                    out_data_q <= res_d;
                    out_cnt_q  <= cnt_d;
                    out_ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench: 32-bit and 16-bit accumulators share stimulus;
// a group-level model predicts each result, monitors pop and compare.
module tb_acc_unit;
    import acc_pkg::*;

    localparam int L = MUL_LAT_DEF;

    typedef struct {
        int     t;
        longint d;
        int     cnt;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic iv  = 1'b0;
    logic il  = 1'b0;
    logic signed [15:0] y = '0;

    logic               ov32, of32, ov16, of16;
    logic signed [31:0] od32;
    logic signed [15:0] od16;
    logic [15:0]        oc32, oc16;

    int     checks = 0;
    int     fails  = 0;
    int     cnum   = 0;
    bit     prev_rst = 1'b1;
    longint grp[$];
    longint ysch[int];
    exp_t   q32[$];
    exp_t   q16[$];
    exp_t   hold[2];

    always #5 clk = ~clk;

    acc_unit #(.MUL_LAT(L), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .clr(clr),
        .issue_valid(iv), .issue_last(il), .y(y),
        .out_valid(ov32), .out_data(od32),
        .out_cnt(oc32), .out_ovf(of32)
    );

    acc_unit #(.MUL_LAT(L), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr),
        .issue_valid(iv), .issue_last(il), .y(y),
        .out_valid(ov16), .out_data(od16),
        .out_cnt(oc16), .out_ovf(of16)
    );

    // Group result from the rules: running saturated sum, sticky flag.
    function automatic exp_t model(input longint v[$], input int w,
                                   input int t);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        longint mn = -(64'sd1 <<< (w - 1));
        longint a = 0;
        bit o = 1'b0;
        exp_t e;
        foreach (v[i]) begin
            a += v[i];
            if (a > mx) begin a = mx; o = 1'b1; end
            else if (a < mn) begin a = mn; o = 1'b1; end
        end
`ifdef ACC_RELU_EN
        if (a < 0) a = 0;
`endif
        e.t = t;
        e.d = a;
        e.cnt = (v.size() > 65535) ? 65535 : v.size();
        e.ovf = o;
        return e;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cnum, act, req);
        end
    endtask

    task automatic step(input bit v, input bit last, input int yv,
                        input bit c, input bit r);
        @(posedge clk);
        cnum++;
        #1;
        iv = v; il = last; clr = c; rst = r;
        y = ysch.exists(cnum) ? 16'(ysch[cnum]) : 16'($urandom);
        if (r || c) begin
            grp.delete();
            while (q32.size() > 0 && q32[$].t >= cnum - L) void'(q32.pop_back());
            while (q16.size() > 0 && q16[$].t >= cnum - L) void'(q16.pop_back());
        end else if (v) begin
            ysch[cnum + L] = yv;
            grp.push_back(yv);
            if (last) begin
                q32.push_back(model(grp, 32, cnum));
                q16.push_back(model(grp, 16, cnum));
                grp.delete();
            end
        end
    endtask

    task automatic iss(input bit last, input int yv);
        step(1'b1, last, yv, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 0, 1'b0, 1'b0);
    endtask

    task automatic mon(input bit wide);
        logic ov, of;
        logic signed [63:0] od;
        logic [15:0] oc;
        exp_t e;
        string s;
        s = wide ? "32" : "16";
        if (wide) begin ov = ov32; od = 64'(od32); oc = oc32; of = of32; end
        else begin ov = ov16; od = 64'(od16); oc = oc16; of = of16; end
        if (prev_rst) begin
            chk({"rst_valid", s}, 64'(ov), 0);
            chk({"rst_data", s}, od, 0);
            chk({"rst_cnt", s}, 64'(oc), 0);
            chk({"rst_ovf", s}, 64'(of), 0);
            hold[wide] = '{t: 0, d: 0, cnt: 0, ovf: 1'b0};
        end else if (ov === 1'b1) begin
            if ((wide ? q32.size() : q16.size()) == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_out%s cyc=%0d got=1 want=0", s, cnum);
            end else begin
                if (wide) e = q32.pop_front(); else e = q16.pop_front();
                chk({"latency", s}, cnum, e.t + L + 1);
                chk({"data", s}, od, e.d);
                chk({"cnt", s}, 64'(oc), e.cnt);
                chk({"ovf", s}, 64'(of), 64'(e.ovf));
                hold[wide] = e;
            end
        end else begin
            chk({"idle_valid", s}, 64'(ov), 0);
            chk({"hold_data", s}, od, hold[wide].d);
            chk({"hold_cnt", s}, 64'(oc), hold[wide].cnt);
            chk({"hold_ovf", s}, 64'(of), 64'(hold[wide].ovf));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(1'b1);
            mon(1'b0);
            prev_rst = rst;
        end
    end

    initial begin
        repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        iss(0, 3); iss(0, -5); iss(0, 7); iss(1, 10);
        idle(8);
        iss(0, 100); iss(1, 200); iss(1, -1);
        idle(8);
        iss(0, 16384); iss(0, 16384); iss(1, 16384);
        idle(8);
        iss(0, 1); iss(0, 2); iss(1, 3);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(8);
        iss(1, 5);
        idle(8);
        iss(0, 1); iss(0, 2);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        iss(1, -7);
        idle(8);
        iss(0, 2); idle(2); iss(1, 4);
        idle(8);
        iss(1, -32768); iss(1, 32767);
        idle(8);
        for (int i = 0; i < 2000; i++) begin
            bit r, c;
            r = ($urandom % 250) == 0;
            c = !r && (($urandom % 120) == 0);
            step(($urandom % 3) != 0, ($urandom % 4) == 0,
                 int'($signed(16'($urandom))), c, r);
        end
        idle(L + 4);
        chk("drain32", q32.size(), 0);
        chk("drain16", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
